// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults and QVGA framebuffer geometry, used by the
// timing reader, the ROI downsampler and the overlay.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam bit VGA_SYNC_POL = 1'b0;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_SHIFT  = 1;
    localparam int FB_RD_LAT = 2;
    localparam int FB_ADDR_W = 17;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register; reset loads every stage with RST_VAL so a flush
// leaves only idle-looking words in flight.
module pipe_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_fb_reader.sv
// Display timing generator that fetches the 2x-upscaled camera framebuffer and
// delays x/y/de/syncs so they line up with the returned pixel.
module vga_timing_fb_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int FB_SHIFT = vga_pkg::FB_SHIFT,
    parameter int RD_LAT   = FB_RD_LAT,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [7:0]        fb_rd_data,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic [7:0]        pix_u8,
    output logic              frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DLY_W   = 24;
    localparam logic [DLY_W-1:0] DLY_RST = {20'd0, 1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [9:0] h_cnt, v_cnt;
    logic       h_last, v_last;
    logic       de0, hs0, vs0, fs0;

    assign h_last = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign de0 = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign hs0 = (h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs0 = (v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign fs0 = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Framebuffer pixel = (line / 2^FB_SHIFT) * FB_W + column / 2^FB_SHIFT
    logic [ADDR_W-1:0] line_base, col, addr_nxt;

    assign line_base = ADDR_W'(v_cnt >> FB_SHIFT) * ADDR_W'(FB_W);
    assign col       = ADDR_W'(h_cnt >> FB_SHIFT);
    assign addr_nxt  = line_base + col;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
        end else begin
            fb_rd_en   <= de0;
            fb_rd_addr <= de0 ? addr_nxt : '0;
        end
    end

    // Sync levels are stored already polarised so the reset value is the idle level.
    logic [DLY_W-1:0] dly_in, dly_out;

    assign dly_in = {h_cnt, v_cnt, de0,
                     hs0 ? SYNC_POL : ~SYNC_POL,
                     vs0 ? SYNC_POL : ~SYNC_POL,
                     fs0};

    pipe_delay #(
        .WIDTH   (DLY_W),
        .DEPTH   (1 + RD_LAT),
        .RST_VAL (DLY_RST)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (dly_in),
        .dout  (dly_out)
    );

    assign {x, y, de, hsync, vsync, frame_start} = dly_out;
    assign pix_u8 = de ? fb_rd_data : 8'd0;

endmodule

// File: tb/tb_vga_timing_fb_reader.sv
// Bench: default-timing instance plus a shrunken-timing instance (short frame,
// active-high sync, latency 3), both checked every cycle against an
// elapsed-time model, with directed line/frame/reset sequences.
module tb_vga_timing_fb_reader;

    typedef struct packed {
        int   ha; int hf; int hs; int hb;
        int   va; int vf; int vs; int vb;
        int   fbw; int lat;
        logic pol;
    } tp_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        en;
        logic [16:0] addr;
    } out_t;

    typedef struct {
        int   inst;
        int   x;
        int   y;
        logic de;
        logic en;
        int   addr;
        int   pix;
    } vec_t;

    localparam tp_t TP0 = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 2, 1'b0};
    localparam tp_t TP1 = '{64, 4, 8, 4, 48, 3, 2, 3, 32, 3, 1'b1};
    localparam int  NV  = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        d0_en, d1_en;
    logic [16:0] d0_addr, d1_addr;
    logic [7:0]  d0_data, d1_data;
    logic [9:0]  d0_x, d0_y, d1_x, d1_y;
    logic        d0_de, d0_hs, d0_vs, d0_fs, d1_de, d1_hs, d1_vs, d1_fs;
    logic [7:0]  d0_pix, d1_pix;

    vga_timing_fb_reader u_d0 (
        .clk(clk), .rst_n(rst_n), .fb_rd_en(d0_en), .fb_rd_addr(d0_addr),
        .fb_rd_data(d0_data), .x(d0_x), .y(d0_y), .de(d0_de), .hsync(d0_hs),
        .vsync(d0_vs), .pix_u8(d0_pix), .frame_start(d0_fs)
    );

    vga_timing_fb_reader #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(3), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .FB_W(32), .FB_SHIFT(1), .RD_LAT(3), .ADDR_W(17)
    ) u_d1 (
        .clk(clk), .rst_n(rst_n), .fb_rd_en(d1_en), .fb_rd_addr(d1_addr),
        .fb_rd_data(d1_data), .x(d1_x), .y(d1_y), .de(d1_de), .hsync(d1_hs),
        .vsync(d1_vs), .pix_u8(d1_pix), .frame_start(d1_fs)
    );

    // Framebuffer models: d0 returns addr[7:0], d1 returns random contents.
    logic [7:0] mem1 [768];
    logic [7:0] q0 [2];
    logic [7:0] q1 [3];
    always @(posedge clk) begin
        q0[0] <= d0_addr[7:0];
        q0[1] <= q0[0];
        q1[0] <= (d1_addr < 17'd768) ? mem1[d1_addr[9:0]] : 8'd0;
        q1[1] <= q1[0];
        q1[2] <= q1[1];
    end
    assign d0_data = q0[1];
    assign d1_data = q1[2];

    int checks = 0;
    int errors = 0;
    int k_cnt  = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) k_cnt <= rst_n ? k_cnt + 1 : 0;

    // Expected outputs from the number of clock edges since reset release.
    function automatic out_t model(input tp_t t, input int k);
        out_t o;
        int ht, vt, p, h, v;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        o = '0;
        o.hs = ~t.pol;
        o.vs = ~t.pol;
        if (k >= 1 + t.lat) begin
            p = k - 1 - t.lat;
            h = p % ht;
            v = (p / ht) % vt;
            o.x  = 10'(h);
            o.y  = 10'(v);
            o.de = (h < t.ha) && (v < t.va);
            o.hs = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.pol : ~t.pol;
            o.vs = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.pol : ~t.pol;
            o.fs = (h == 0) && (v == 0);
        end
        if (k >= 1) begin
            p = k - 1;
            h = p % ht;
            v = (p / ht) % vt;
            if (h < t.ha && v < t.va) begin
                o.en   = 1'b1;
                o.addr = 17'((v / 2) * t.fbw + h / 2);
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] exp_pix(input int inst, input out_t o);
        int a;
        if (!o.de) return 8'd0;
        if (inst == 0) begin
            a = (int'(o.y) / 2) * 320 + int'(o.x) / 2;
            return 8'(a);
        end
        a = (int'(o.y) / 2) * 32 + int'(o.x) / 2;
        return mem1[a];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    vec_t tbl [NV];
    logic hit [NV];
    logic [16:0] ah0 [5], ah1 [5];
    logic        eh0 [5], eh1 [5];

    always @(negedge clk) begin
        out_t e0, e1, a0, a1;
        logic [7:0] p0, p1;
        logic [16:0] ga;
        logic        ge, gd;
        logic [7:0]  gp;
        int gx, gy, lat;
        for (int i = 4; i > 0; i--) begin
            ah0[i] = ah0[i-1]; ah1[i] = ah1[i-1];
            eh0[i] = eh0[i-1]; eh1[i] = eh1[i-1];
        end
        ah0[0] = d0_addr; ah1[0] = d1_addr;
        eh0[0] = d0_en;   eh1[0] = d1_en;
        if (chk_en) begin
            e0 = model(TP0, k_cnt);
            e1 = model(TP1, k_cnt);
            p0 = exp_pix(0, e0);
            p1 = exp_pix(1, e1);
            a0 = {d0_x, d0_y, d0_de, d0_hs, d0_vs, d0_fs, d0_en, d0_addr};
            a1 = {d1_x, d1_y, d1_de, d1_hs, d1_vs, d1_fs, d1_en, d1_addr};
            checks += 2;
            if (a0 !== e0 || d0_pix !== p0) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL model_d0 k=%0d: got %h pix %h expected %h pix %h", k_cnt, a0, d0_pix, e0, p0);
            end
            if (a1 !== e1 || d1_pix !== p1) begin
                errors++;
                if (errors <= 30)
                    $display("FAIL model_d1 k=%0d: got %h pix %h expected %h pix %h", k_cnt, a1, d1_pix, e1, p1);
            end
            for (int i = 0; i < NV; i++) begin
                lat = (tbl[i].inst == 0) ? TP0.lat : TP1.lat;
                gx  = (tbl[i].inst == 0) ? int'(d0_x) : int'(d1_x);
                gy  = (tbl[i].inst == 0) ? int'(d0_y) : int'(d1_y);
                if (!hit[i] && k_cnt >= 1 + lat && gx == tbl[i].x && gy == tbl[i].y) begin
                    hit[i] = 1'b1;
                    gd = (tbl[i].inst == 0) ? d0_de : d1_de;
                    ge = (tbl[i].inst == 0) ? eh0[lat] : eh1[lat];
                    ga = (tbl[i].inst == 0) ? ah0[lat] : ah1[lat];
                    gp = (tbl[i].inst == 0) ? d0_pix : d1_pix;
                    checks++;
                    if (gd !== tbl[i].de || ge !== tbl[i].en || ga !== 17'(tbl[i].addr) || gp !== 8'(tbl[i].pix)) begin
                        errors++;
                        $display("FAIL vec%0d (%0d,%0d): got de=%b en=%b addr=%0d pix=%0d expected de=%b en=%b addr=%0d pix=%0d",
                                 i, tbl[i].x, tbl[i].y, gd, ge, ga, gp,
                                 tbl[i].de, tbl[i].en, tbl[i].addr, tbl[i].pix);
                    end
                end
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, f1, de_cnt, hs_cnt, hs_first, hs_last;
        int fs_cnt, vs_cnt, vmin, vmax, lines;
        logic ok;

        for (int i = 0; i < 768; i++) mem1[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            ah0[i] = '0; ah1[i] = '0; eh0[i] = 1'b0; eh1[i] = 1'b0;
        end
        tbl[0]  = '{0, 0,   0, 1'b1, 1'b1, 0,   0};
        tbl[1]  = '{0, 1,   0, 1'b1, 1'b1, 0,   0};
        tbl[2]  = '{0, 5,   0, 1'b1, 1'b1, 2,   2};
        tbl[3]  = '{0, 2,   1, 1'b1, 1'b1, 1,   1};
        tbl[4]  = '{0, 0,   2, 1'b1, 1'b1, 320, 64};
        tbl[5]  = '{0, 8,   4, 1'b1, 1'b1, 644, 132};
        tbl[6]  = '{0, 639, 4, 1'b1, 1'b1, 959, 191};
        tbl[7]  = '{0, 700, 0, 1'b0, 1'b0, 0,   0};
        tbl[8]  = '{0, 660, 3, 1'b0, 1'b0, 0,   0};
        tbl[9]  = '{1, 63, 47, 1'b1, 1'b1, 767, int'(mem1[767])};
        tbl[10] = '{1, 70, 50, 1'b0, 1'b0, 0,   0};
        tbl[11] = '{1, 10, 50, 1'b0, 1'b0, 0,   0};
        for (int i = 0; i < NV; i++) hit[i] = 1'b0;

        // Reset held 10 cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rst_d0_flags", {d0_de, d0_en, d0_hs, d0_vs, d0_fs}, 64'b00110);
        check("rst_d1_flags", {d1_de, d1_en, d1_hs, d1_vs, d1_fs}, 64'b00000);
        check("rst_d0_addr", d0_addr, 64'd0);

        // Release and time the first aligned de
        @(posedge clk); #2 rst_n = 1'b1;
        f0 = -1; f1 = -1;
        for (n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (f0 < 0 && d0_de) begin
                f0 = n;
                check("first_de_xy", {d0_x, d0_y}, 64'd0);
            end
            if (f1 < 0 && d1_de) f1 = n;
        end
        check("first_de_lat_d0", f0, 64'd3);
        check("first_de_lat_d1", f1, 64'd4);

        // One full line of the default instance starting at x=0,y=1
        n = 0;
        do begin @(negedge clk); n++; end while (!(d0_x == 0 && d0_y == 1 && d0_de) && n < 2000);
        check("line_start_found", n < 2000, 64'd1);
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (d0_de) de_cnt++;
            if (d0_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d0_x);
                hs_last = int'(d0_x);
            end
            @(negedge clk);
        end
        check("line_period_xy", {d0_x, d0_y, d0_de}, {10'd0, 10'd2, 1'b1});
        check("line_de_cnt", de_cnt, 64'd640);
        check("line_hs_cnt", hs_cnt, 64'd96);
        check("line_hs_first", hs_first, 64'd656);
        check("line_hs_last", hs_last, 64'd751);

        // One full frame of the shrunken instance
        n = 0;
        do begin @(negedge clk); n++; end while (!d1_fs && n < 10000);
        check("frame_fs_found", n < 10000, 64'd1);
        check("frame_fs_align", {d1_x, d1_y, d1_de}, {10'd0, 10'd0, 1'b1});
        fs_cnt = 0; vs_cnt = 0; vmin = 1000; vmax = -1; lines = 0;
        for (int i = 0; i < 4480; i++) begin
            if (d1_fs) fs_cnt++;
            if (d1_x == 0) lines++;
            if (d1_vs == 1'b1) begin
                vs_cnt++;
                if (int'(d1_y) < vmin) vmin = int'(d1_y);
                if (int'(d1_y) > vmax) vmax = int'(d1_y);
            end
            @(negedge clk);
        end
        check("frame_fs_once", fs_cnt, 64'd1);
        check("frame_fs_period", d1_fs, 64'd1);
        check("frame_lines", lines, 64'd56);
        check("frame_vs_cnt", vs_cnt, 64'd160);
        check("frame_vs_first", vmin, 64'd51);
        check("frame_vs_last", vmax, 64'd52);

        // One-cycle reset in mid frame
        n = 0;
        do begin @(negedge clk); n++; end while (!(d1_x == 30 && d1_y == 20) && n < 6000);
        check("mid_point_found", n < 6000, 64'd1);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        f0 = -1; f1 = -1; fs_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("mid_rst_d0", {d0_x, d0_y, d0_de, d0_en, d0_hs, d0_vs, d0_fs, d0_pix},
                      {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
                check("mid_rst_d1", {d1_x, d1_y, d1_de, d1_en, d1_hs, d1_vs, d1_fs, d1_pix},
                      {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
            end
            if (d0_fs && f0 < 0) f0 = i;
            if (d1_fs && f1 < 0) f1 = i;
            if (d0_fs || d1_fs) fs_cnt++;
        end
        check("mid_fs_d0_at", f0, 64'd3);
        check("mid_fs_d1_at", f1, 64'd4);
        check("mid_fs_count", fs_cnt, 64'd2);

        // Random reset pulses over free running; the per-cycle model checks all of it
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(300, 2500)) @(posedge clk);
            #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (1000) @(posedge clk);
        @(negedge clk);

        ok = 1'b1;
        for (int i = 0; i < NV; i++)
            if (!hit[i]) begin
                ok = 1'b0;
                $display("FAIL vec%0d_reached: got 0 expected 1", i);
            end
        check("vectors_reached", ok, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_fb_reader.md
Name: vga_timing_fb_reader

Overview:
- Generates 640x480@60 display timing (x, y, de, hsync, vsync) on the pixel clock.
- Issues read addresses into the QVGA grayscale camera framebuffer, upscaled 2x2.
- Delays all timing signals to match the framebuffer BRAM read latency, so x/y/de/pixel arrive aligned at the ROI box overlay stage downstream.
- The same aligned stream also feeds the 28x28 ROI downsampler.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch
SYNC_POL, 0, asserted sync level (0 = active-low)
FB_W, 320, framebuffer line width in pixels
FB_SHIFT, 1, log2 of the upscale factor
RD_LAT, 2, framebuffer read latency in clk cycles (rd_addr to rd_data), >=1
ADDR_W, 17, framebuffer address width

Ports:
clk  in  1  pixel clock (25.175/25 MHz)
rst_n  in  1  synchronous active-low reset
fb_rd_en  out  1  framebuffer read enable
fb_rd_addr  out  ADDR_W  framebuffer read address
fb_rd_data  in  8  framebuffer grayscale data, valid RD_LAT cycles after address
x  out  10  aligned horizontal counter
y  out  10  aligned vertical counter
de  out  1  aligned active-video flag
hsync  out  1  aligned hsync
vsync  out  1  aligned vsync
pix_u8  out  8  aligned pixel, 0 when de=0
frame_start  out  1  one-cycle pulse, aligned with x=0,y=0

Behaviour:
- Single clock domain. Reset is synchronous, active-low; every register is updated only on the rising clk edge.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Counters h_cnt/v_cnt:
  - h_cnt increments every clk.
  - At h_cnt = H_TOTAL-1: h_cnt goes to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 with h wrap: v_cnt goes to 0.
- Stage-0 decode from counters:
  - de0 = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs0 is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs0 is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - fs0 = (h_cnt==0 && v_cnt==0).
- Address, registered, valid at t+1 for counters at t:
  - fb_rd_addr = (v_cnt>>FB_SHIFT)*FB_W + (h_cnt>>FB_SHIFT).
  - fb_rd_en = de0.
  - When de0=0, fb_rd_addr holds 0.
  - Constant multiply or incremental line-base accumulator is allowed; the result must equal the formula bit-exactly.
  - Maximum address is 239*320+319 = 76799, which fits 17 bits.
- Alignment:
  - {h_cnt, v_cnt, de0, hs0, vs0, fs0} pass through a delay line of depth 1+RD_LAT.
  - Outputs at cycle t+1+RD_LAT correspond to counters at t.
  - pix_u8 = de ? fb_rd_data : 0 (combinational mux on the aligned de).
- Sync polarity: output is SYNC_POL when asserted, ~SYNC_POL otherwise.
- Reset values:
  - Counters 0; fb_rd_en 0; fb_rd_addr 0.
  - Delay line cleared (de 0, frame_start 0, x/y 0).
  - hsync/vsync = ~SYNC_POL.
- After reset release:
  - The first counter value is (0,0).
  - The first aligned de=1 appears 1+RD_LAT cycles later.
- Reset mid-frame:
  - Frame restarts at (0,0).
  - No partial or stale de/frame_start pulse leaks out; the delay line is flushed by reset.
- No back-pressure: the stream is free-running. The framebuffer must honour RD_LAT every cycle.
- Counter wrap and sync assertion on the same cycle (e.g. v wrap during vsync end) follow the decode above with no special case.

Decomposition:
- Package vga_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL derivation functions, FB_W/FB_H constants shared with the ROI downsampler and overlay.
- Sub-module pipe_delay (parameterised width/depth, sync active-low reset to a parameter value) for the alignment delay line.
- The top holds the counters, decode and address generation.

Test Plan:
- Reset: hold rst_n=0 10 cycles -> de=0, fb_rd_en=0, hsync=vsync=1, frame_start=0. Release -> first aligned de=1 exactly 3 cycles later with x=0,y=0.
- Line timing: measure one line -> period 800 cycles, de high 640 cycles, hsync low for 96 cycles at x=656..751.
- Frame timing: measure one frame -> 525 lines, vsync low on y=490..491, frame_start exactly once per 420000 cycles, aligned with x=0,y=0,de=1.
- Address map: check (x=0,y=0)->0, (1,0)->0, (2,1)->1, (0,2)->320, (639,479)->76799; blanking -> fb_rd_en=0, addr 0.
- Alignment: BRAM model with latency 2 returning addr[7:0] -> at x=5,y=0 pix_u8=2; at x=8,y=4 pix_u8=(640+4)&255=132; pix_u8=0 whenever de=0.
- Reset mid-frame: assert rst_n=0 for 1 cycle at y=200,x=300 -> all outputs return to reset values, counters restart at (0,0), no spurious frame_start before the next true one.
